sram_bist_sequencer: RTL
========================

// Module: sram_bist_sequencer
// PURPOSE
//  Built-in self-test sequencer for the cryo SRAM. One start pulse runs two passes over an address range:
//   - write pass: pattern to every address via the write-cycle engine;
//   - read pass: read every address via the read-cycle engine and compare.
//  Counts mismatches, captures the first failing address, and reports pass/fail to the FPGA top level.
//  It issues start pulses only; SRAM pin timing stays inside the engines.
// PARAMETERS
//  ADDR_W   9      address width
//  DATA_W   8      data width
//  ADDR_LO  0      first address tested
//  ADDR_HI  511    last address tested (ADDR_HI >= ADDR_LO)
//  TIMEOUT  64     max clk_in cycles from an engine start to its done pulse
// PORTS
//  clk_in              in   1       system clock (100 MHz); one clock; reset is synchronous and active-high
//  reset_in            in   1       synchronous active-high reset
//  start_in            in   1       1-cycle pulse, begins test (ignored unless IDLE/DONE)
//  abort_in            in   1       level/pulse, returns to IDLE at next edge
//  pattern_in          in   DATA_W  base data pattern, sampled on accepted start
//  a_out               out  ADDR_W  current address to both engines
//  d_out               out  DATA_W  expected/write data for current address
//  wr_start_out        out  1       1-cycle start pulse to write engine
//  wr_done_in          in   1       1-cycle done pulse from write engine
//  rd_start_out        out  1       1-cycle start pulse to read engine
//  rd_done_in          in   1       1-cycle done pulse from read engine
//  rd_data_in          in   DATA_W  read data, valid when rd_done_in=1
//  busy_out            out  1       high from accepted start until DONE/IDLE
//  done_out            out  1       1-cycle pulse on entering DONE
//  pass_out            out  1       in DONE: 1 iff err_count==0 and no timeout
//  err_count_out       out  16      mismatch count, saturates at 16'hFFFF
//  first_err_addr_out  out  ADDR_W  address of first mismatch (0 if none)
//  timeout_out         out  1       sticky: an engine failed to finish in TIMEOUT cycles
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 (a_out, d_out, counts, flags, pulses).
//  States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE.
//  IDLE/DONE + start_in: latch pattern; a_out=ADDR_LO; clear err_count, first_err_addr, timeout, pass.
//   Then busy=1 -> WR_ISSUE.
//  WR_ISSUE: wr_start_out=1 for exactly one cycle; watchdog cleared -> WR_WAIT.
//  WR_WAIT: on wr_done_in:
//   - a_out==ADDR_HI: a_out=ADDR_LO -> RD_ISSUE.
//   - otherwise: a_out+1 -> WR_ISSUE.
//  RD_ISSUE: rd_start_out=1 for one cycle -> RD_WAIT.
//  RD_WAIT: on rd_done_in, compare rd_data_in vs d_out in the same cycle.
//   - On mismatch, err_count+1 (saturating).
//   - If this is the first mismatch, first_err_addr=a_out.
//   - a_out==ADDR_HI -> DONE; else a_out+1 -> RD_ISSUE.
//  Per-address latency: issue cycle + engine latency; no back-to-back starts (min 2 cycles apart).
//  Watchdog: counts cycles in WR_WAIT/RD_WAIT. On reaching TIMEOUT: timeout_out=1 -> DONE.
//   The address is not advanced; pass_out=0.
//  DONE: done_out pulse on entry; busy=0; results held until next accepted start or reset.
//  done pulse outside a WAIT state: ignored. Done in the same cycle the watchdog expires: done wins.
//  start_in while busy: ignored. abort_in has priority over all except reset:
//   - -> IDLE; busy=0; no done pulse; counters hold.
//  reset_in mid-operation: immediate IDLE; start pulses drop the same edge.
//  d_out derives from latched pattern and a_out; updates with a_out.
//  ADDR_LO==ADDR_HI: one write, one read.
// CONFIGURATION
//  SRAM_BIST_ADDR_XOR_EN defined: d_out = pattern ^ a_out[DATA_W-1:0] (address-unique data, catches aliasing).
//  Undefined: d_out = pattern for every address.
// TESTING
//  Engine models: done 4 cycles after start; read returns model memory. ADDR_LO=0, ADDR_HI=7 unless noted.
//  1 Clean run, pattern 8'hA5 -> 8 wr_start then 8 rd_start pulses; done_out once; pass=1; err=0.
//  2 Model corrupts addr 3 and 5 -> err_count=2, first_err_addr=3, pass=0.
//  3 Read engine never sends done at addr 2 -> timeout_out=1 after 64 cycles; DONE; pass=0; a_out=2.
//  4 abort_in during write pass at addr 4 -> IDLE next edge; busy=0; no done_out; start pulses stop.
//  5 reset_in mid read pass, then start_in with 8'h3C -> outputs 0 at reset; rerun passes; err cleared.
//  6 SRAM_BIST_ADDR_XOR_EN, pattern 8'hFF -> d_out at addr 5 = 8'hFA; without macro = 8'hFF.

Source files
------------

// File: rtl/sram_bist_sequencer.sv
// sram_bist_sequencer
//   BIST sequencer for the cryo SRAM. A single accepted start runs a write
//   pass followed by a read/compare pass over ADDR_LO..ADDR_HI. It drives only
//   start pulses plus address/data to the write and read cycle engines. It
//   counts mismatches, captures the first failing address, and flags an engine
//   that never answers.
//
//   Optional feature macro: SRAM_BIST_ADDR_XOR_EN
//     defined   : d_out = pattern ^ address (address-unique data)
//     undefined : d_out = pattern for every address
module sram_bist_sequencer #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int ADDR_LO = 0,
  parameter int ADDR_HI = 511,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic [DATA_W-1:0] pattern_in,
  output logic [ADDR_W-1:0] a_out,
  output logic [DATA_W-1:0] d_out,
  output logic              wr_start_out,
  input  logic              wr_done_in,
  output logic              rd_start_out,
  input  logic              rd_done_in,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              pass_out,
  output logic [15:0]       err_count_out,
  output logic [ADDR_W-1:0] first_err_addr_out,
  output logic              timeout_out
);

  localparam int                WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(ADDR_LO);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(ADDR_HI);
  localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(TIMEOUT - 1);
  localparam logic [15:0]       ERR_MAX    = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_WR_WAIT  = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

`ifdef SRAM_BIST_ADDR_XOR_EN
  // Address-unique data: low address bits folded into the pattern.
  function automatic logic [DATA_W-1:0] addr_data(input logic [DATA_W-1:0] pattern,
                                                  input logic [ADDR_W-1:0] addr);
    return pattern ^ DATA_W'(addr);
  endfunction
`else
  // Same data at every address.
  function automatic logic [DATA_W-1:0] addr_data(input logic [DATA_W-1:0] pattern);
    return pattern;
  endfunction
`endif

  state_t              state_q,    state_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [DATA_W-1:0]   data_q,     data_d;
  logic [DATA_W-1:0]   pattern_q,  pattern_d;
  logic                wr_start_q, wr_start_d;
  logic                rd_start_q, rd_start_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                pass_q,     pass_d;
  logic [15:0]         err_q,      err_d;
  logic [ADDR_W-1:0]   first_q,    first_d;
  logic                timeout_q,  timeout_d;
  logic [WD_W-1:0]     wdog_q,     wdog_d;

  // Next-state, address walk, compare and watchdog logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pattern_d = pattern_q;
    err_d     = err_q;
    first_d   = first_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    wdog_d    = wdog_q;

    if (abort_in) begin
      // Abort wins over everything but reset; results and address hold.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_in) begin
            pattern_d = pattern_in;
            addr_d    = ADDR_FIRST;
            err_d     = 16'h0000;
            first_d   = '0;
            timeout_d = 1'b0;
            pass_d    = 1'b0;
            state_d   = S_WR_ISSUE;
          end else begin
            state_d = state_q;
          end
        end
        S_WR_ISSUE: begin
          wdog_d  = '0;
          state_d = S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (wr_done_in) begin
            // A done arriving on the expiry cycle is still accepted.
            if (addr_q == ADDR_LAST) begin
              addr_d  = ADDR_FIRST;
              state_d = S_RD_ISSUE;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_WR_ISSUE;
            end
          end else if (wdog_q == WD_LIMIT) begin
            timeout_d = 1'b1;
            pass_d    = 1'b0;
            state_d   = S_DONE;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
        S_RD_ISSUE: begin
          wdog_d  = '0;
          state_d = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (rd_done_in) begin
            if (rd_data_in != data_q) begin
              if (err_q != ERR_MAX) begin
                err_d = err_q + 16'd1;
              end else begin
                err_d = err_q;
              end
              // Count only ever leaves zero on the first mismatch of a run.
              if (err_q == 16'h0000) begin
                first_d = addr_q;
              end else begin
                first_d = first_q;
              end
            end else begin
              err_d = err_q;
            end
            if (addr_q == ADDR_LAST) begin
              pass_d  = (err_d == 16'h0000);
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_RD_ISSUE;
            end
          end else if (wdog_q == WD_LIMIT) begin
            timeout_d = 1'b1;
            pass_d    = 1'b0;
            state_d   = S_DONE;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Issue states always last exactly one cycle, so these are single pulses.
    wr_start_d = (state_d == S_WR_ISSUE);
    rd_start_d = (state_d == S_RD_ISSUE);
    busy_d     = (state_d == S_WR_ISSUE) || (state_d == S_WR_WAIT) ||
                 (state_d == S_RD_ISSUE) || (state_d == S_RD_WAIT);
    done_d     = (state_d == S_DONE) && (state_q != S_DONE);
`ifdef SRAM_BIST_ADDR_XOR_EN
    data_d     = addr_data(pattern_d, addr_d);
`else
    data_d     = addr_data(pattern_d);
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      pattern_q  <= '0;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 16'h0000;
      first_q    <= '0;
      timeout_q  <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      pattern_q  <= pattern_d;
      wr_start_q <= wr_start_d;
      rd_start_q <= rd_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      first_q    <= first_d;
      timeout_q  <= timeout_d;
      wdog_q     <= wdog_d;
    end
  end

  assign a_out              = addr_q;
  assign d_out              = data_q;
  assign wr_start_out       = wr_start_q;
  assign rd_start_out       = rd_start_q;
  assign busy_out           = busy_q;
  assign done_out           = done_q;
  assign pass_out           = pass_q;
  assign err_count_out      = err_q;
  assign first_err_addr_out = first_q;
  assign timeout_out        = timeout_q;

endmodule
